// File: rtl/mem_pkg.sv
// Shared definitions for the memory access sequencer and its control unit:
// FSM state encodings, default bus widths and the rnw polarity constants.
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_wdog.sv
// Saturating MFC watchdog counter. Besides expired (count == TIMEOUT) it flags
// the last count before expiry so the sequencer can stop exactly on the limit.
module mem_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic inc,
  output logic expired,
  output logic penult
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear)
      count_next = '0;
    else if (inc && (count_reg != LIMIT))
      count_next = count_reg + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) count_reg <= '0;
    else     count_reg <= count_next;
  end

  assign expired = (count_reg == LIMIT);
  assign penult  = (count_reg == LIMIT - 1'b1);

endmodule

// File: rtl/mem_ctrl.sv
// Initiator side of the CPU-RAM handshake: latches a single-beat request,
// drives MAR/rnw/bus/enable, waits for MFC rise and fall, reports done/err.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic              req_rnw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] MAR,
  output logic              enable,
  output logic              rnw,
  output logic [DATA_W-1:0] bus,
  input  logic [DATA_W-1:0] MBR,
  input  logic              MFC
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] mar_reg, mar_next;
  logic [DATA_W-1:0] bus_reg, bus_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              rnw_reg, rnw_next;
  logic              enable_reg, enable_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  logic wd_clear, wd_inc, wd_expired, wd_penult;
  logic limit_hit;

  mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (wd_clear),
    .inc     (wd_inc),
    .expired (wd_expired),
    .penult  (wd_penult)
  );

  // This increment is the one that lands the counter on TIMEOUT.
  assign limit_hit = wd_penult | wd_expired;

  always_comb begin
    state_next  = state_reg;
    mar_next    = mar_reg;
    bus_next    = bus_reg;
    rdata_next  = rdata_reg;
    rnw_next    = rnw_reg;
    enable_next = enable_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    wd_clear    = 1'b0;
    wd_inc      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          mar_next   = req_addr;
          rnw_next   = req_rnw;
          bus_next   = req_wdata;
          state_next = SETUP;
        end
      end
      SETUP: begin
        enable_next = 1'b1;
        wd_clear    = 1'b1;
        state_next  = WAIT;
      end
      WAIT: begin
        if (MFC) begin
          enable_next = 1'b0;
          if (rnw_reg == READ) rdata_next = MBR;
          wd_clear   = 1'b1;
          state_next = RELEASE;
        end else begin
          wd_inc = 1'b1;
          if (limit_hit) begin
            enable_next = 1'b0;
            done_next   = 1'b1;
            err_next    = 1'b1;
            state_next  = IDLE;
          end
        end
      end
      RELEASE: begin
        if (!MFC) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          wd_inc = 1'b1;
          if (limit_hit) begin
            done_next  = 1'b1;
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      mar_reg    <= '0;
      bus_reg    <= '0;
      rdata_reg  <= '0;
      rnw_reg    <= READ;
      enable_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mar_reg    <= mar_next;
      bus_reg    <= bus_next;
      rdata_reg  <= rdata_next;
      rnw_reg    <= rnw_next;
      enable_reg <= enable_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  assign MAR    = mar_reg;
  assign bus    = bus_reg;
  assign rdata  = rdata_reg;
  assign rnw    = rnw_reg;
  assign enable = enable_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign err    = err_reg;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-side access sequencer for the microprocessor: the initiator end of the CPU–RAM handshake. It takes single-beat read/write requests from the control unit, drives the RAM's address register, enable, read/not-write and data bus, then waits for memory-function-complete (MFC). It captures read data from the memory buffer register (MBR) and reports completion or timeout. It sits between the control unit/datapath and the ram block.

## Interface
- ADDR_W, 8, address width (MAR).
- DATA_W, 8, data width (bus/MBR).
- TIMEOUT, 15, max cycles waited for each MFC edge; legal range 1..255.
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset; asynchronous, active-high.
- req  input  1  request strobe; sampled only in IDLE.
- req_rnw  input  1  1 = read, 0 = write.
- req_addr  input  ADDR_W  access address.
- req_wdata  input  DATA_W  write data.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse, coincident with done, on timeout.
- rdata  output  DATA_W  last successfully read data; held until next successful read.
- MAR  output  ADDR_W  address to RAM.
- enable  output  1  access enable to RAM.
- rnw  output  1  read/not-write to RAM.
- bus  output  DATA_W  write data to RAM.
- MBR  input  DATA_W  read data from RAM.
- MFC  input  1  memory-function-complete from RAM.

## Operation
- All outputs are registered. Reset values: MAR=0, bus=0, rnw=1, enable=0, busy=0, done=0, err=0, rdata=0.
- rnw resets to 1 so no write can occur out of reset.
- FSM states: IDLE, SETUP, WAIT, RELEASE.
- IDLE, req=1: latch req_addr→MAR, req_rnw→rnw, req_wdata→bus; go to SETUP. req=0: stay in IDLE.
- SETUP: set enable=1, clear the timeout counter, go to WAIT. This gives one full cycle of address/rnw/bus setup before enable rises.
- WAIT, MFC=1: enable=0. If rnw=1, load MBR→rdata. Clear the counter and go to RELEASE.
- WAIT, MFC=0: increment the counter. When the counter reaches TIMEOUT, set enable=0, pulse done and err, and go to IDLE. rdata is unchanged on timeout.
- RELEASE, MFC=0: pulse done and go to IDLE.
- RELEASE, MFC=1: increment the counter. At TIMEOUT, pulse done and err and go to IDLE.
- MAR, rnw and bus hold their values from IDLE exit until the next accepted request.
- req while busy is ignored; nothing is queued.
- The counter is ceil(log2(TIMEOUT+1)) bits wide and never wraps.
- Writes: the RAM commits on every CLK edge while enable=1 and rnw=0. Repeated commits are benign because MAR and bus are stable throughout.

## Timing
- Take req as sampled at edge N, with MFC responding within the cycle enable is high.
- Edge N+1: enable=1.
- Edge N+2: MFC sampled; enable=0; rdata valid.
- Edge N+3: MFC low sampled; done=1 for the cycle after N+3.
- Minimum request-to-done latency is 4 edges.
- Earliest back-to-back request: req sampled in the cycle done is high is accepted, because the state is IDLE then.
- Timeout in WAIT: enable stays high for exactly TIMEOUT cycles after SETUP; done/err follow on the next edge.
- Reset asserted mid-access: enable drops asynchronously, the FSM goes to IDLE and no done is produced. The RAM sees a negedge on enable, which clears MFC.
- MFC is sampled synchronously only; no combinational path from MFC to any output.

## Structure
- Shared package mem_pkg holds:
  - state encodings (IDLE=2'd0, SETUP=2'd1, WAIT=2'd2, RELEASE=2'd3);
  - ADDR_W and DATA_W defaults;
  - the READ=1 / WRITE=0 rnw constants, shared with the control unit.
- Sub-module mem_wdog: saturating timeout counter with clear, inc and expired (count==TIMEOUT) outputs, parameterized by TIMEOUT.

## Test plan
- Read: RAM preloaded addr 0x08=0x01; req, rnw=1, addr=0x08 → enable high for exactly 1 cycle, rdata=0x01, done 4 edges after req, err=0.
- Write then read: write 0x5A to 0x20, then read 0x20 → second access returns rdata=0x5A; rnw=0 only during the write; bus=0x5A held.
- Timeout: MFC tied 0, TIMEOUT=15 → enable high 15 cycles, then done=err=1 for one cycle, enable=0, rdata unchanged.
- Stuck MFC: MFC forced 1 after WAIT → RELEASE times out after 15 cycles with err=1.
- Busy ignore / back-to-back: req held high during an access to 0x01 while req_addr changes to 0x02 mid-access → MAR stays 0x01; the next access starts the cycle after done with MAR=0x02.
- Reset mid-WAIT: assert RST while enable=1 → enable, busy, done go 0 immediately; rnw=1, MAR=0; the next req completes normally.
